// File: rtl/solver_done_monitor.sv
// Turns the asynchronous solver-done level into sticky, countable, maskable completion events.
// Define SOLVER_DONE_LATENCY_EN to build the run-latency counter and the LATENCY register.
module solver_done_monitor #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        done_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned ADDR_STATUS  = 0;
  localparam int unsigned ADDR_MASK    = 1;
  localparam int unsigned ADDR_COUNT   = 2;
  localparam int unsigned ADDR_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             sync_v1, sync_v2;
  logic             rise, fall;
  logic             wr, status_clr, count_clr, mask_wr, event_hit;
  logic             pending, overflow, irq_mask;
  logic [CNT_W-1:0] count;
  logic             unused_wdata;

  // Three-flop synchroniser; sync_v2 marks when s2 reflects a real sample of done_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      sync_v1 <= 1'b0;
      sync_v2 <= 1'b0;
    end else begin
      s1      <= done_in;
      s2      <= s1;
      s3      <= s2;
      sync_v1 <= 1'b1;
      sync_v2 <= sync_v1;
    end
  end

  assign rise       = s2 & ~s3;
  assign fall       = ~s2 & s3;
  assign wr         = chipselect & ~write_n;
  assign status_clr = wr && (address == 2'(ADDR_STATUS)) && writedata[1];
  assign mask_wr    = wr && (address == 2'(ADDR_MASK));
  assign count_clr  = wr && (address == 2'(ADDR_COUNT));
  assign event_hit  = (state == ARMED) && rise;

  assign unused_wdata = ^writedata[31:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (sync_v2 && !s2) state <= ARMED;
        ARMED:    if (rise) state <= COMPLETE;
        COMPLETE: if (fall) state <= ARMED;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef SOLVER_DONE_LATENCY_EN
  logic [CNT_W-1:0] lat_cnt, lat_reg;

  // lat_cnt restarts on every entry to ARMED and is captured on the completing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
      lat_reg <= '0;
    end else begin
      case (state)
        IDLE:     if (sync_v2 && !s2) lat_cnt <= '0;
        ARMED: begin
          if (rise)                lat_reg <= lat_cnt;
          else if (lat_cnt != '1)  lat_cnt <= lat_cnt + CNT_W'(1);
        end
        COMPLETE: if (fall) lat_cnt <= '0;
        default:  lat_cnt <= '0;
      endcase
    end
  end
`endif

  // A new event always wins over a software clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
      irq_mask <= 1'b0;
      count    <= '0;
    end else begin
      if (mask_wr) irq_mask <= writedata[0];

      if (event_hit) begin
        pending <= 1'b1;
        if (pending && !status_clr) overflow <= 1'b1;
      end else if (status_clr) begin
        pending  <= 1'b0;
        overflow <= 1'b0;
      end

      if (event_hit) begin
        if (count_clr)          count <= CNT_W'(1);
        else if (count != '1)   count <= count + CNT_W'(1);
      end else if (count_clr) begin
        count <= '0;
      end
    end
  end

  assign irq = pending & irq_mask;

  always_comb begin
    readdata = '0;
    case (address)
      2'(ADDR_STATUS):  readdata[4:0] = {state, overflow, pending, s2};
      2'(ADDR_MASK):    readdata[0] = irq_mask;
      2'(ADDR_COUNT):   readdata[CNT_W-1:0] = count;
`ifdef SOLVER_DONE_LATENCY_EN
      2'(ADDR_LATENCY): readdata[CNT_W-1:0] = lat_reg;
`endif
      default:          readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_solver_done_monitor.sv
// Directed bench for solver_done_monitor: edge latency, sticky flags, simultaneous clears, reset cases.
module tb_solver_done_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        done_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  solver_done_monitor #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done_in    (done_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] lat_exp(input int v);
`ifdef SOLVER_DONE_LATENCY_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  // done low for low_cycles sampling edges, then high; caller is left just after the raise.
  task automatic run(input int low_cycles);
    done_in = 1'b0;
    tick(low_cycles);
    done_in = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; done_in = 1'b0; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    check_reg("rst_status", 2'd0, 32'h0);
    check_reg("rst_mask", 2'd1, 32'h0);
    check_reg("rst_count", 2'd2, 32'h0);
    check_reg("rst_lat", 2'd3, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    // Armed from reset: ARMED entered at the 3rd edge once the synchroniser is valid.
    tick(5);
    check_reg("armed_status", 2'd0, 32'h08);
    check("armed_irq", 32'(irq), 32'h0);
    check_reg("armed_count", 2'd2, 32'h0);
    bus_write(2'd1, 32'h1);
    tick(94);
    done_in = 1'b1;
    tick(2);
    check("irq_before_3edges", 32'(irq), 32'h0);
    tick(1);
    check("irq_after_3edges", 32'(irq), 32'h1);
    check_reg("run1_status", 2'd0, 32'h13);
    check_reg("run1_count", 2'd2, 32'h1);
    check_reg("run1_lat", 2'd3, lat_exp(99));
    check_reg("mask_rb", 2'd1, 32'h1);

    // Second event while pending: overflow; low for 10 edges gives 9 cycles in ARMED.
    run(10);
    tick(3);
    check_reg("ovf_status", 2'd0, 32'h17);
    check_reg("ovf_count", 2'd2, 32'h2);
    check_reg("ovf_lat", 2'd3, lat_exp(9));
    bus_write(2'd0, 32'h5);
    check_reg("wr0_noeffect", 2'd0, 32'h17);
    check("wr0_irq", 32'(irq), 32'h1);
    bus_write(2'd0, 32'h2);
    check_reg("clr_status", 2'd0, 32'h11);
    check("clr_irq", 32'(irq), 32'h0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    check_reg("lat_wr_ignored", 2'd3, lat_exp(9));

    // STATUS clear on the rise cycle, pending previously 0.
    run(10);
    tick(2);
    bus_write(2'd0, 32'h2);
    check_reg("race_status", 2'd0, 32'h13);
    check("race_irq", 32'(irq), 32'h1);
    check_reg("race_count", 2'd2, 32'h3);

    // STATUS clear on the rise cycle with pending=1: overflow neither set nor cleared.
    run(10);
    tick(2);
    bus_write(2'd0, 32'h2);
    check_reg("race2_status", 2'd0, 32'h13);
    check_reg("race2_count", 2'd2, 32'h4);

    // COUNT clear on the rise cycle leaves 1; overflow sets.
    run(10);
    tick(2);
    bus_write(2'd2, 32'h0);
    check_reg("cclr_count", 2'd2, 32'h1);
    check_reg("cclr_status", 2'd0, 32'h17);

    // STATUS clear on rise with overflow already 1 keeps it.
    run(10);
    tick(2);
    bus_write(2'd0, 32'h2);
    check_reg("race3_status", 2'd0, 32'h17);
    check_reg("race3_count", 2'd2, 32'h2);
    bus_write(2'd2, 32'h1234);
    check_reg("count_wr_clr", 2'd2, 32'h0);

    // done high through reset: no event until done is seen low.
    reset_n = 1'b0;
    done_in = 1'b1;
    tick(2);
    reset_n = 1'b1;
    bus_write(2'd1, 32'h1);
    tick(19);
    check_reg("hi_idle_status", 2'd0, 32'h01);
    check_reg("hi_idle_count", 2'd2, 32'h0);
    check("hi_idle_irq", 32'(irq), 32'h0);
    run(10);
    tick(3);
    check_reg("hi_event_status", 2'd0, 32'h13);
    check_reg("hi_event_count", 2'd2, 32'h1);
    check("hi_event_irq", 32'(irq), 32'h1);
    check_reg("hi_event_lat", 2'd3, lat_exp(9));

    // Reset while ARMED with lat_cnt at 50.
    done_in = 1'b0;
    tick(53);
    reset_n = 1'b0;
    check_reg("midrst_status", 2'd0, 32'h0);
    check_reg("midrst_mask", 2'd1, 32'h0);
    check_reg("midrst_count", 2'd2, 32'h0);
    check_reg("midrst_lat", 2'd3, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    done_in = 1'b1;
    tick(3);
    check_reg("post_rst_count", 2'd2, 32'h1);
    check_reg("post_rst_status", 2'd0, 32'h13);
    check_reg("post_rst_lat", 2'd3, lat_exp(19));
    check("post_rst_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/solver_done_monitor.md
# solver_done_monitor

Consumes the 1-bit solver-done level driven by the done PIO and turns it into CPU-visible completion events. It synchronises the level and detects its rising edge. It latches a sticky pending flag, counts completions and measures run latency. It raises a maskable interrupt. It sits on the same Avalon-MM bus as the PIO, as a zero-wait-state slave with combinational `readdata`.

## Interface
- `CNT_W`, 32: width of the completion counter and the latency counter/register (1..32).
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `done_in` in 1: solver-done level from the PIO `out_port`; treated as asynchronous.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux of the selected register; unused bits read 0.
- `irq` out 1: `pending & irq_mask`; combinational from registers.

## Operation
- Synchroniser: `s1 <= done_in`, `s2 <= s1`, `s3 <= s2`; `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- FSM states: IDLE, ARMED, COMPLETE. Reset state is IDLE.
  - IDLE: if `s2 == 0`, go to ARMED and clear `lat_cnt`. Otherwise stay in IDLE; a done that is high out of reset never produces an event.
  - ARMED: `lat_cnt` increments each cycle and saturates at all-ones. On `rise`:
    - go to COMPLETE;
    - `lat_reg <= lat_cnt`;
    - increment `count`, saturating at all-ones;
    - set `pending`;
    - if `pending` was already 1, set `overflow`.
  - COMPLETE: on `fall`, go to ARMED and clear `lat_cnt`.
- Register map (word addresses):
  - 0, STATUS:
    - read: bit0 = `s2`, bit1 = `pending`, bit2 = `overflow`, bits[4:3] = state (IDLE=0, ARMED=1, COMPLETE=2).
    - write: writing 1 to bit1 clears `pending` and `overflow`; writing 0 has no effect.
  - 1, MASK: bit0 = `irq_mask`, read/write.
  - 2, COUNT: read returns `count` zero-extended. Any write clears it.
  - 3, LATENCY: read returns `lat_reg` zero-extended. Writes are ignored.
- Simultaneous events:
  - A STATUS clear in the same cycle as a new event leaves `pending` = 1 and `overflow` unchanged.
  - A COUNT clear in the same cycle as an event leaves `count` = 1.
- Reset values: all state registers are 0, FSM is IDLE, `irq` = 0, `readdata` = 0 for every address.
- Reset mid-run: all state is lost and the FSM returns to IDLE. An in-flight run is not reported, even if done later rises, unless done is first seen low.

## Timing
- `done_in` sampled high at edge N:
  - `s2` is high after edge N+1;
  - `pending`, `count`, `lat_reg` and `irq` update at edge N+2, i.e. a 3-edge latency.
- `fall` behaves the same way: the transition to ARMED occurs at edge N+2 after `done_in` is sampled low.
- Latency value: the number of cycles spent in ARMED before the `rise` cycle. `done_in` low for L cycles after the synchroniser settles gives L, ±1 for asynchronous sampling.
- Writes take effect at the next clock edge. Reads are same-cycle with no wait states.
- `done_in` pulses shorter than 1 clock may be missed. This is acceptable because the PIO drive is a level.

## Configuration
- `SOLVER_DONE_LATENCY_EN` defined: `lat_cnt` and `lat_reg` are built, and address 3 returns the latency.
- Undefined: both registers are removed and address 3 reads 0. The FSM, COUNT and IRQ behaviour are unchanged.

## Test plan
- Reset with `done_in` = 0 and hold 5 cycles -> STATUS reads 0x08 (ARMED), `irq` = 0, COUNT = 0.
- Write MASK = 1, hold `done_in` low 100 cycles, then high -> 3 edges after sampling: `irq` = 1, STATUS bit1 = 1, COUNT = 1, LATENCY = 100 ±1 (macro defined) or 0 (undefined).
- With `pending` = 1, drop `done_in` then raise it again -> STATUS bit2 = 1, COUNT = 2. Write STATUS 0x2 -> STATUS bits[2:1] = 0 and `irq` = 0.
- Issue a STATUS write 0x2 in the exact cycle `rise` is true -> `pending` remains 1 and `irq` stays asserted.
- Hold `done_in` = 1 through reset and for 20 cycles -> state stays IDLE (STATUS bits[4:3] = 0), COUNT = 0, no `irq`. Then low 10 cycles, then high -> one event is recorded.
- Pulse `reset_n` low while in ARMED at `lat_cnt` = 50 -> all registers read 0, and the next run's LATENCY starts from 0.
